pu_stream_responder: RTL

- Memory-side counterpart of a processing unit's data ports, used in the mem_controller testbenches.
- Read side: acts as the source for the PU's read port. It streams deterministic, tagged input words (read_data, read_id, read_d_type) and paces them with a read_ready/read_req handshake.
- Write side: acts as the sink for the PU's write port. It accepts write_data into a capture FIFO and applies back-pressure via write_ready.
- The bench drains the capture FIFO through a separate port for checking.

---
 rtl/pu_stream_responder_if.sv | 47 ++++
 rtl/pu_stream_responder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pu_stream_responder_if.sv
// Handshake bundle between a PU-side driver and the memory-side stream responder:
// read-stream source, write-capture sink and the capture FIFO drain port.
interface pu_stream_responder_if #(
  parameter int OP_WIDTH       = 16,
  parameter int NUM_PE         = 4,
  parameter int D_TYPE_W       = 2,
  parameter int RD_LOOP_W      = 10,
  parameter int NUM_WORDS_W    = 16,
  parameter int WR_FIFO_ADDR_W = 4
);
  localparam int DATA_W = OP_WIDTH * NUM_PE;

  logic                      start;
  logic [NUM_WORDS_W-1:0]    cfg_num_words;
  logic [RD_LOOP_W-1:0]      cfg_num_loops;
  logic [D_TYPE_W-1:0]       cfg_d_type;
  logic [OP_WIDTH-1:0]       cfg_seed;
  logic                      busy;
  logic                      done;
  logic [DATA_W-1:0]         read_data;
  logic [RD_LOOP_W-1:0]      read_id;
  logic [D_TYPE_W-1:0]       read_d_type;
  logic                      read_ready;
  logic                      read_req;
  logic                      write_req;
  logic [DATA_W-1:0]         write_data;
  logic                      write_ready;
  logic                      drain_req;
  logic [DATA_W-1:0]         drain_data;
  logic                      drain_valid;
  logic [WR_FIFO_ADDR_W:0]   wr_count;
  logic                      overflow;

  modport master (
    output start, cfg_num_words, cfg_num_loops, cfg_d_type, cfg_seed,
    output read_req, write_req, write_data, drain_req,
    input  busy, done, read_data, read_id, read_d_type, read_ready,
    input  write_ready, drain_data, drain_valid, wr_count, overflow
  );

  modport slave (
    input  start, cfg_num_words, cfg_num_loops, cfg_d_type, cfg_seed,
    input  read_req, write_req, write_data, drain_req,
    output busy, done, read_data, read_id, read_d_type, read_ready,
    output write_ready, drain_data, drain_valid, wr_count, overflow
  );
endinterface

// File: rtl/pu_stream_responder.sv
// Memory-side model of a PU's data ports: streams tagged, seeded words on the read
// side and captures pushed words into a drainable FIFO on the write side.
module pu_stream_responder #(
  parameter int OP_WIDTH       = 16,
  parameter int NUM_PE         = 4,
  parameter int D_TYPE_W       = 2,
  parameter int RD_LOOP_W      = 10,
  parameter int NUM_WORDS_W    = 16,
  parameter int WR_FIFO_ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  pu_stream_responder_if.slave    bus
);
  localparam int DATA_W = OP_WIDTH * NUM_PE;
  localparam int DEPTH  = 1 << WR_FIFO_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_start_acc;
  logic [NUM_WORDS_W-1:0]    r_word;
  logic [RD_LOOP_W-1:0]      r_loop;
  logic [NUM_WORDS_W-1:0]    r_num_words;
  logic [RD_LOOP_W-1:0]      r_num_loops;
  logic [D_TYPE_W-1:0]       r_d_type;
  logic [OP_WIDTH-1:0]       r_seed;
  logic                      w_pop;
  logic                      w_last_word;
  logic                      w_last_loop;
  logic [OP_WIDTH-1:0]       w_word_base;
  logic [DATA_W-1:0]         w_lanes;

  logic [DATA_W-1:0]         r_mem [DEPTH];
  logic [WR_FIFO_ADDR_W-1:0] r_wr_ptr;
  logic [WR_FIFO_ADDR_W-1:0] r_rd_ptr;
  logic [WR_FIFO_ADDR_W:0]   r_count;
  logic                      r_overflow;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_push;
  logic                      w_drain;

  assign w_pop       = (r_state == ST_STREAM) && bus.read_req;
  assign w_last_word = (r_word == r_num_words - NUM_WORDS_W'(1));
  assign w_last_loop = (r_loop == r_num_loops - RD_LOOP_W'(1));

  // Next-state logic; a zero-length stream goes straight to DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_start_acc = 1'b1;
          if ((bus.cfg_num_words == '0) || (bus.cfg_num_loops == '0)) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_STREAM;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (w_pop && w_last_word && w_last_loop) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_STREAM;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Configuration latch and word/loop counters; loop keeps its last value after the stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word      <= '0;
      r_loop      <= '0;
      r_num_words <= '0;
      r_num_loops <= '0;
      r_d_type    <= '0;
      r_seed      <= '0;
    end else if (w_start_acc) begin
      r_word      <= '0;
      r_loop      <= '0;
      r_num_words <= bus.cfg_num_words;
      r_num_loops <= bus.cfg_num_loops;
      r_d_type    <= bus.cfg_d_type;
      r_seed      <= bus.cfg_seed;
    end else if (w_pop) begin
      if (w_last_word) begin
        r_word <= '0;
        if (!w_last_loop) begin
          r_loop <= r_loop + RD_LOOP_W'(1);
        end
      end else begin
        r_word <= r_word + NUM_WORDS_W'(1);
      end
    end
  end

  assign w_word_base = OP_WIDTH'(r_word) * OP_WIDTH'(NUM_PE);

  always_comb begin
    w_lanes = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      w_lanes[k*OP_WIDTH +: OP_WIDTH] = r_seed + w_word_base + OP_WIDTH'(k);
    end
  end

  assign bus.busy        = (r_state == ST_STREAM);
  assign bus.read_ready  = (r_state == ST_STREAM);
  assign bus.done        = (r_state == ST_DONE);
  assign bus.read_data   = (r_state == ST_STREAM) ? w_lanes : '0;
  assign bus.read_id     = r_loop;
  assign bus.read_d_type = r_d_type;

  // Capture FIFO: pops use the pre-cycle occupancy, so push+pop on empty only pushes.
  assign w_full  = (r_count == (WR_FIFO_ADDR_W+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.write_req && !w_full;
  assign w_drain = bus.drain_req && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.write_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + WR_FIFO_ADDR_W'(1);
      end
      if (w_drain) begin
        r_rd_ptr <= r_rd_ptr + WR_FIFO_ADDR_W'(1);
      end
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + (WR_FIFO_ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (WR_FIFO_ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      r_overflow <= (r_overflow && !w_start_acc) || (bus.write_req && w_full);
    end
  end

  assign bus.write_ready = !w_full;
  assign bus.drain_valid = !w_empty;
  assign bus.drain_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.wr_count    = r_count;
  assign bus.overflow    = r_overflow;
endmodule
